// File: rtl/fetch_mem_arbiter.sv
// Shares one single-port memory between the fetch stage and the load/store stage.
// One access in flight at a time: IDLE decides, ISSUE drives the port, WAIT covers latency, RESP returns data.
module fetch_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MEM_LATENCY  = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              fetch_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [2:0] LAT_INIT   = 3'(MEM_LATENCY - 1);

  logic [1:0]        state_reg;
  logic              owner_data_reg;
  logic              we_reg;
  logic              cancel_reg;
  logic [3:0]        streak_reg;
  logic [2:0]        lat_reg;
  logic              mem_en_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [DATA_W-1:0] if_rdata_reg;
  logic [DATA_W-1:0] d_rdata_reg;

  logic fetch_eff;
  logic grant_any;
  logic grant_data;
  logic resp_cycle;

  // A cancel arriving in IDLE hides the fetch request for that decision only.
  assign fetch_eff  = if_req & ~if_cancel;
  assign grant_any  = d_req | fetch_eff;
  assign grant_data = d_req & ~(fetch_eff & (streak_reg == STREAK_MAX));

  // Response pulses are gated by reset so an abandoned access never reports.
  assign resp_cycle  = (state_reg == S_RESP) & ~reset;
  assign if_valid    = resp_cycle & ~owner_data_reg & ~cancel_reg & ~if_cancel;
  assign d_done      = resp_cycle & owner_data_reg;
  assign if_rdata    = if_valid ? mem_rdata : if_rdata_reg;
  assign d_rdata     = d_done ? (we_reg ? '0 : mem_rdata) : d_rdata_reg;
  assign fetch_stall = if_req & ~if_valid;

  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      owner_data_reg <= 1'b0;
      we_reg         <= 1'b0;
      cancel_reg     <= 1'b0;
      streak_reg     <= '0;
      lat_reg        <= '0;
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      if_rdata_reg   <= '0;
      d_rdata_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_any) begin
            owner_data_reg <= grant_data;
            we_reg         <= grant_data & d_we;
            cancel_reg     <= 1'b0;
            mem_en_reg     <= 1'b1;
            mem_we_reg     <= grant_data & d_we;
            mem_addr_reg   <= grant_data ? d_addr : if_addr;
            if (grant_data) begin
              mem_wdata_reg <= d_wdata;
            end
            // Streak only grows while fetch is being held off by data.
            if (grant_data && if_req) begin
              if (streak_reg != STREAK_MAX) begin
                streak_reg <= streak_reg + 4'd1;
              end
            end else begin
              streak_reg <= '0;
            end
            state_reg <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_en_reg <= 1'b0;
          mem_we_reg <= 1'b0;
          lat_reg    <= LAT_INIT;
          if (!owner_data_reg && if_cancel) begin
            cancel_reg <= 1'b1;
          end
          state_reg <= (MEM_LATENCY == 1) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          lat_reg <= lat_reg - 3'd1;
          if (!owner_data_reg && if_cancel) begin
            cancel_reg <= 1'b1;
          end
          if (lat_reg == 3'd1) begin
            state_reg <= S_RESP;
          end
        end
        default: begin
          if (if_valid) begin
            if_rdata_reg <= mem_rdata;
          end
          if (d_done) begin
            d_rdata_reg <= we_reg ? '0 : mem_rdata;
          end
          cancel_reg <= 1'b0;
          state_reg  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Scoreboard bench: two arbiter instances (latency 1 and 3) each with a behavioural memory.
// Stimulus pushes expected responses; per-instance monitors pop and compare on every pulse.
module tb_fetch_mem_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct packed {
    logic        is_data;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Instance A signals
  logic reset_a, if_req_a, if_cancel_a, if_valid_a, fetch_stall_a;
  logic d_req_a, d_we_a, d_done_a, mem_en_a, mem_we_a;
  logic [15:0] if_addr_a, if_rdata_a, d_addr_a, d_wdata_a, d_rdata_a;
  logic [15:0] mem_addr_a, mem_wdata_a, mem_rdata_a;
  // Instance B signals
  logic reset_b, if_req_b, if_cancel_b, if_valid_b, fetch_stall_b;
  logic d_req_b, d_we_b, d_done_b, mem_en_b, mem_we_b;
  logic [15:0] if_addr_b, if_rdata_b, d_addr_b, d_wdata_b, d_rdata_b;
  logic [15:0] mem_addr_b, mem_wdata_b, mem_rdata_b;

  fetch_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(LAT_A), .MAX_D_STREAK(4)) u_dut_a (
    .clk(clk), .reset(reset_a),
    .if_req(if_req_a), .if_addr(if_addr_a), .if_cancel(if_cancel_a),
    .if_valid(if_valid_a), .if_rdata(if_rdata_a), .fetch_stall(fetch_stall_a),
    .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
    .d_done(d_done_a), .d_rdata(d_rdata_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a)
  );

  fetch_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(LAT_B), .MAX_D_STREAK(4)) u_dut_b (
    .clk(clk), .reset(reset_b),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_cancel(if_cancel_b),
    .if_valid(if_valid_b), .if_rdata(if_rdata_b), .fetch_stall(fetch_stall_b),
    .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
    .d_done(d_done_b), .d_rdata(d_rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b)
  );

  // Default memory contents: 0x0000 -> 0x1234, 0x0040 -> 0xBEEF, otherwise 0xC000 | addr[7:0].
  function automatic logic [15:0] init_word(input logic [7:0] a);
    case (a)
      8'h00:   return 16'h1234;
      8'h40:   return 16'hBEEF;
      default: return 16'hC000 | {8'h00, a};
    endcase
  endfunction

  logic [15:0] mem_arr_a [256];
  bit          wr_a      [256];
  logic [15:0] pipe_a    [LAT_A];
  assign mem_rdata_a = pipe_a[LAT_A-1];
  always @(posedge clk) begin
    if (mem_en_a && mem_we_a) begin
      mem_arr_a[mem_addr_a[7:0]] <= mem_wdata_a;
      wr_a[mem_addr_a[7:0]]      <= 1'b1;
    end
    pipe_a[0] <= mem_en_a ? (wr_a[mem_addr_a[7:0]] ? mem_arr_a[mem_addr_a[7:0]]
                                                   : init_word(mem_addr_a[7:0])) : 16'hDEAD;
    for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
  end

  logic [15:0] mem_arr_b [256];
  bit          wr_b      [256];
  logic [15:0] pipe_b    [LAT_B];
  assign mem_rdata_b = pipe_b[LAT_B-1];
  always @(posedge clk) begin
    if (mem_en_b && mem_we_b) begin
      mem_arr_b[mem_addr_b[7:0]] <= mem_wdata_b;
      wr_b[mem_addr_b[7:0]]      <= 1'b1;
    end
    pipe_b[0] <= mem_en_b ? (wr_b[mem_addr_b[7:0]] ? mem_arr_b[mem_addr_b[7:0]]
                                                   : init_word(mem_addr_b[7:0])) : 16'hDEAD;
    for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
  end

  exp_t q_a[$];
  exp_t q_b[$];
  int pulses_a = 0, pulses_b = 0;
  int last_cyc_a = 0, last_cyc_b = 0;
  exp_t got_a, exp_a, got_b, exp_b;

  always @(negedge clk) begin
    if (if_valid_a || d_done_a) begin
      got_a = '{is_data: d_done_a, data: (d_done_a ? d_rdata_a : if_rdata_a)};
      pulses_a++;
      last_cyc_a = cyc;
      checks++;
      if (if_valid_a && d_done_a) begin
        errors++;
        $display("FAIL a_both_pulses: if_valid=1 and d_done=1 together, required one at a time");
      end else if (q_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_resp: got kind=%0d data=%h, required no response", got_a.is_data, got_a.data);
      end else begin
        exp_a = q_a.pop_front();
        if (got_a !== exp_a) begin
          errors++;
          $display("FAIL a_resp: got kind=%0d data=%h, required kind=%0d data=%h",
                   got_a.is_data, got_a.data, exp_a.is_data, exp_a.data);
        end else begin
          $display("a resp ok: kind=%0d data=%h cycle=%0d", got_a.is_data, got_a.data, cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (if_valid_b || d_done_b) begin
      got_b = '{is_data: d_done_b, data: (d_done_b ? d_rdata_b : if_rdata_b)};
      pulses_b++;
      last_cyc_b = cyc;
      checks++;
      if (if_valid_b && d_done_b) begin
        errors++;
        $display("FAIL b_both_pulses: if_valid=1 and d_done=1 together, required one at a time");
      end else if (q_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_resp: got kind=%0d data=%h, required no response", got_b.is_data, got_b.data);
      end else begin
        exp_b = q_b.pop_front();
        if (got_b !== exp_b) begin
          errors++;
          $display("FAIL b_resp: got kind=%0d data=%h, required kind=%0d data=%h",
                   got_b.is_data, got_b.data, exp_b.is_data, exp_b.data);
        end else begin
          $display("b resp ok: kind=%0d data=%h cycle=%0d", got_b.is_data, got_b.data, cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("check ok: %s = %h", name, act);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulses_a(input int n, input int budget, input string name);
    int start = pulses_a;
    int k = 0;
    while ((pulses_a - start) < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if ((pulses_a - start) < n) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d cycles, got %0d pulses, required %0d", name, budget, pulses_a - start, n);
    end
  endtask

  task automatic wait_pulses_b(input int n, input int budget, input string name);
    int start = pulses_b;
    int k = 0;
    while ((pulses_b - start) < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if ((pulses_b - start) < n) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d cycles, got %0d pulses, required %0d", name, budget, pulses_b - start, n);
    end
  endtask

  int p1, t0;

  initial begin
    reset_a = 1'b1; if_req_a = 1'b0; if_addr_a = '0; if_cancel_a = 1'b0;
    d_req_a = 1'b0; d_we_a = 1'b0; d_addr_a = '0; d_wdata_a = '0;
    reset_b = 1'b1; if_req_b = 1'b0; if_addr_b = '0; if_cancel_b = 1'b0;
    d_req_b = 1'b0; d_we_b = 1'b0; d_addr_b = '0; d_wdata_b = '0;

    // Reset held for two cycles: every output reads zero.
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_if_valid", 32'(if_valid_a), 32'd0);
    chk("rst_if_rdata", 32'(if_rdata_a), 32'd0);
    chk("rst_fetch_stall", 32'(fetch_stall_a), 32'd0);
    chk("rst_d_done", 32'(d_done_a), 32'd0);
    chk("rst_d_rdata", 32'(d_rdata_a), 32'd0);
    chk("rst_mem_en", 32'(mem_en_a), 32'd0);
    chk("rst_mem_we", 32'(mem_we_a), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr_a), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata_a), 32'd0);

    // Fetch only from address 0 right at reset release (cycle 1 = first cycle with reset low).
    next_cycle();
    reset_a = 1'b0; if_req_a = 1'b1; if_addr_a = 16'h0000;
    q_a.push_back('{is_data: 1'b0, data: 16'h1234});
    @(negedge clk);
    chk("f1_c1_stall", 32'(fetch_stall_a), 32'd1);
    chk("f1_c1_mem_en", 32'(mem_en_a), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("f1_c2_mem_en", 32'(mem_en_a), 32'd1);
    chk("f1_c2_mem_addr", 32'(mem_addr_a), 32'h0000);
    chk("f1_c2_stall", 32'(fetch_stall_a), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("f1_c3_if_valid", 32'(if_valid_a), 32'd1);
    chk("f1_c3_if_rdata", 32'(if_rdata_a), 32'h1234);
    chk("f1_c3_stall", 32'(fetch_stall_a), 32'd0);

    // Simultaneous fetch and data read: data first, fetch on the following IDLE.
    next_cycle();
    if_req_a = 1'b1; if_addr_a = 16'h0002;
    d_req_a = 1'b1; d_we_a = 1'b0; d_addr_a = 16'h0040;
    q_a.push_back('{is_data: 1'b1, data: 16'hBEEF});
    q_a.push_back('{is_data: 1'b0, data: 16'hC002});
    wait_pulses_a(1, 10, "both_data_timeout");
    p1 = last_cyc_a;
    next_cycle();
    d_req_a = 1'b0;
    wait_pulses_a(1, 10, "both_fetch_timeout");
    chk("both_fetch_gap", 32'(last_cyc_a - p1), 32'd3);
    next_cycle();
    if_req_a = 1'b0;

    // Data held continuously against a waiting fetch: 4 data, 1 fetch, then data again.
    next_cycle();
    if_req_a = 1'b1; if_addr_a = 16'h0002;
    d_req_a = 1'b1; d_we_a = 1'b0; d_addr_a = 16'h0050;
    for (int i = 0; i < 4; i++) q_a.push_back('{is_data: 1'b1, data: 16'hC050});
    q_a.push_back('{is_data: 1'b0, data: 16'hC002});
    q_a.push_back('{is_data: 1'b1, data: 16'hC050});
    wait_pulses_a(6, 40, "streak_timeout");
    next_cycle();
    if_req_a = 1'b0; d_req_a = 1'b0;

    // Data write then read-back of the same address.
    next_cycle();
    d_req_a = 1'b1; d_we_a = 1'b1; d_addr_a = 16'h0010; d_wdata_a = 16'hA5A5;
    q_a.push_back('{is_data: 1'b1, data: 16'h0000});
    @(negedge clk);
    chk("wr_c1_mem_we", 32'(mem_we_a), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("wr_c2_mem_en", 32'(mem_en_a), 32'd1);
    chk("wr_c2_mem_we", 32'(mem_we_a), 32'd1);
    chk("wr_c2_mem_addr", 32'(mem_addr_a), 32'h0010);
    chk("wr_c2_mem_wdata", 32'(mem_wdata_a), 32'hA5A5);
    next_cycle();
    @(negedge clk);
    chk("wr_c3_mem_we", 32'(mem_we_a), 32'd0);
    chk("wr_c3_d_done", 32'(d_done_a), 32'd1);
    next_cycle();
    d_we_a = 1'b0;
    q_a.push_back('{is_data: 1'b1, data: 16'hA5A5});
    wait_pulses_a(1, 10, "rdback_timeout");
    next_cycle();
    d_req_a = 1'b0;

    // Instance B (latency 3): cancel during WAIT, redirect to 0x0020.
    next_cycle();
    reset_b = 1'b0; if_req_b = 1'b1; if_addr_b = 16'h0030;
    t0 = cyc;
    q_b.push_back('{is_data: 1'b0, data: 16'hC020});
    next_cycle();
    next_cycle();
    if_cancel_b = 1'b1; if_addr_b = 16'h0020;
    next_cycle();
    if_cancel_b = 1'b0;
    wait_pulses_b(1, 20, "cancel_timeout");
    chk("cancel_resp_cycle", 32'(last_cyc_b - t0), 32'd9);
    next_cycle();
    if_req_b = 1'b0;

    // Reset during WAIT: abandoned fetch gives no pulse, held request restarts with full latency.
    next_cycle();
    if_req_b = 1'b1; if_addr_b = 16'h0060;
    q_b.push_back('{is_data: 1'b0, data: 16'hC060});
    next_cycle();
    next_cycle();
    reset_b = 1'b1;
    next_cycle();
    reset_b = 1'b0;
    t0 = cyc;
    @(negedge clk);
    chk("rstw_mem_en", 32'(mem_en_b), 32'd0);
    chk("rstw_mem_addr", 32'(mem_addr_b), 32'h0000);
    wait_pulses_b(1, 20, "rstw_timeout");
    chk("rstw_resp_cycle", 32'(last_cyc_b - t0), 32'd4);
    next_cycle();
    if_req_b = 1'b0;

    repeat (8) next_cycle();
    chk("a_queue_empty", 32'(q_a.size()), 32'd0);
    chk("b_queue_empty", 32'(q_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
